// File: rtl/sparc_pkg.sv
// Shared SPARC datapath constants and the operand-fetch state encoding.
package sparc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG_ADDR = '0;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        CAP,
        OUT
    } of_state_t;

endpackage

// File: rtl/operand_fetch.sv
// Operand-fetch stage: sequences rs1/rs2 reads through the single-port register
// file and owns its write port, granting writebacks only when no read is in flight.
module operand_fetch
    import sparc_pkg::*;
#(
    parameter int DATA_W   = sparc_pkg::DATA_W,
    parameter int ADDR_W   = sparc_pkg::ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG_ADDR);

    of_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rs1_q, rs2_q;
    logic              wb_write;

    // Writes to r0 are acknowledged but never reach the register file.
    assign wb_write = wb_valid && ((wb_addr != R0) || !ZERO_REG);

    // NOTE: every sequential target uses <= so all registers update from
    // pre-edge values; a blocking = here would create order-dependent logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                rs1_q <= rs1;
                rs2_q <= rs2;
            end
            // rf_rdata lags the address by one cycle: RD2 sees rs1's data, CAP sees rs2's.
            if (state_q == RD2)
                op_a <= (ZERO_REG && rs1_q == R0) ? '0 : rf_rdata;
            if (state_q == CAP) begin
                op_b     <= (ZERO_REG && rs2_q == R0) ? '0 : rf_rdata;
                op_valid <= 1'b1;
            end
            if (state_q == OUT && op_ready)
                op_valid <= 1'b0;
        end
    end

    // NOTE: every output and next-state is given a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rf_write  = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                wb_ready  = 1'b1;
                rf_write  = wb_write;
                rf_addr   = wb_write ? wb_addr : '0;
                rf_wdata  = wb_data;
                if (req_valid)
                    state_d = RD1;
            end
            RD1: begin
                rf_addr = rs1_q;
                state_d = RD2;
            end
            RD2: begin
                rf_addr = rs2_q;
                state_d = CAP;
            end
            CAP: state_d = OUT;
            OUT: begin
                wb_ready = 1'b1;
                rf_write = wb_write;
                rf_addr  = wb_write ? wb_addr : '0;
                rf_wdata = wb_data;
                if (op_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so outputs must be gated explicitly while it is held.
        if (!rst_n) begin
            req_ready = 1'b0;
            wb_ready  = 1'b0;
            rf_write  = 1'b0;
            rf_addr   = '0;
            rf_wdata  = '0;
        end
    end

endmodule
